// File: rtl/mem_pkg.sv
// Shared types and constants for the main-memory responder.
package mem_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BURST_LEN = 8;
  // Low address bits cleared to align a line-fill base to a line boundary
  localparam int unsigned OFFSET_W  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_t;

endpackage

// File: rtl/mem_word_array.sv
// Word storage: synchronous write port, combinational read port, no reset.
module mem_word_array
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WORD_W-1:0]    wr_data,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WORD_W-1:0]    rd_data
);

  logic [WORD_W-1:0] mem [2**ADDR_BITS];

  // Write port: one word per edge when enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/main_memory_responder.sv
// Memory end of the L2 fill/write-through interface: single-word writes,
// single or line-fill reads returned as a beat stream after a fixed latency.
module main_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned BURST_LEN = mem_pkg::BURST_LEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_index,
  input  logic              mem_write_index,
  input  logic              burst,
  input  logic [31:0]       addr_to_mem,
  input  logic [WORD_W-1:0] data_to_mem,
  output logic [WORD_W-1:0] data_from_mem,
  output logic              rvalid,
  output logic              rlast,
  output logic              wack,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

  state_t               state;
  logic [3:0]           lat_cnt;
  logic [CNT_W-1:0]     beat_cnt;
  logic [CNT_W-1:0]     beats;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] idx;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [WORD_W-1:0]    rd_data;
  logic                 wr_en;
  logic                 unused_addr;

  assign idx         = addr_to_mem[ADDR_BITS-1:0];
  assign unused_addr = ^addr_to_mem[31:ADDR_BITS];
  assign wr_en       = (state == IDLE) && mem_write_index;
  assign rd_addr     = base + ADDR_BITS'(beat_cnt);
  assign busy        = (state != IDLE);

  mem_word_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk    (clk),
    .we     (wr_en),
    .wr_addr(idx),
    .wr_data(data_to_mem),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Request arbitration, latency wait and beat sequencing with registered outputs.
  // BEAT spends one extra cycle after issuing the last beat so busy stays high
  // through the rlast cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      beat_cnt      <= '0;
      beats         <= '0;
      base          <= '0;
      data_from_mem <= '0;
      rvalid        <= 1'b0;
      rlast         <= 1'b0;
      wack          <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      rlast  <= 1'b0;
      wack   <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_write_index) begin
            wack <= 1'b1;
          end else if (mem_read_index) begin
            base     <= burst ? {idx[ADDR_BITS-1:OFFSET_W], OFFSET_W'(0)} : idx;
            beats    <= burst ? CNT_W'(BURST_LEN) : CNT_W'(1);
            beat_cnt <= '0;
            if (LATENCY == 0) begin
              state <= BEAT;
            end else begin
              state   <= WAIT;
              lat_cnt <= 4'(LATENCY);
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt <= 4'd1) begin
            state   <= BEAT;
            lat_cnt <= '0;
          end
        end
        BEAT: begin
          if (rlast) begin
            state <= IDLE;
          end else begin
            data_from_mem <= rd_data;
            rvalid        <= 1'b1;
            rlast         <= (beat_cnt == beats - CNT_W'(1));
            beat_cnt      <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_main_memory_responder.sv
// Directed self-checking bench for main_memory_responder (LATENCY=2 and LATENCY=0 instances).
module tb_main_memory_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_index;
  logic        mem_write_index;
  logic        burst;
  logic [31:0] addr_to_mem;
  logic [31:0] data_to_mem;
  logic [31:0] data_from_mem, data_from_mem0;
  logic        rvalid, rvalid0;
  logic        rlast, rlast0;
  logic        wack, wack0;
  logic        busy, busy0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [31:0] exp_q [8];

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  main_memory_responder #(
    .ADDR_BITS(10),
    .LATENCY  (LAT),
    .BURST_LEN(8)
  ) u_dut (
    .clk            (clk),
    .rst            (rst),
    .mem_read_index (mem_read_index),
    .mem_write_index(mem_write_index),
    .burst          (burst),
    .addr_to_mem    (addr_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem),
    .rvalid         (rvalid),
    .rlast          (rlast),
    .wack           (wack),
    .busy           (busy)
  );

  main_memory_responder #(
    .ADDR_BITS(10),
    .LATENCY  (0),
    .BURST_LEN(8)
  ) u_dut0 (
    .clk            (clk),
    .rst            (rst),
    .mem_read_index (mem_read_index),
    .mem_write_index(mem_write_index),
    .burst          (burst),
    .addr_to_mem    (addr_to_mem),
    .data_to_mem    (data_to_mem),
    .data_from_mem  (data_from_mem0),
    .rvalid         (rvalid0),
    .rlast          (rlast0),
    .wack           (wack0),
    .busy           (busy0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    mem_write_index = 1'b1;
    addr_to_mem     = a;
    data_to_mem     = d;
    tick();
    chk("wack_pulse", {31'b0, wack}, 32'd1);
    chk("busy_on_write", {31'b0, busy}, 32'd0);
    mem_write_index = 1'b0;
    tick();
    chk("wack_one_cycle", {31'b0, wack}, 32'd0);
  endtask

  // Issue a read, then follow both instances for a bounded number of cycles.
  task automatic do_read(input logic [31:0] a, input logic b, input int n);
    int got = 0, first = -1, got0 = 0, first0 = -1, rlast_c = -10;
    mem_read_index = 1'b1;
    burst          = b;
    addr_to_mem    = a;
    tick();
    mem_read_index = 1'b0;
    burst          = 1'b0;
    chk("busy_after_accept", {31'b0, busy}, 32'd1);
    for (int c = 1; c <= n + LAT + 3; c++) begin
      tick();
      if (rlast_c > 0 && c == rlast_c + 1) chk("busy_after_last", {31'b0, busy}, 32'd0);
      if (rvalid) begin
        if (got == 0) first = c;
        if (got < n) chk("beat_data", data_from_mem, exp_q[got]);
        chk("rlast_pos", {31'b0, rlast}, {31'b0, (got == n - 1)});
        chk("beat_gapless", c, first + got);
        if (rlast) begin
          chk("busy_in_last", {31'b0, busy}, 32'd1);
          rlast_c = c;
        end
        got++;
      end else begin
        if (rlast) chk("rlast_without_rvalid", {31'b0, rlast}, 32'd0);
      end
      if (rvalid0) begin
        if (got0 == 0) first0 = c;
        if (got0 < n) chk("beat_data_lat0", data_from_mem0, exp_q[got0]);
        got0++;
      end
    end
    chk("beat_count", got, n);
    chk("first_beat_cycle", first, LAT + 1);
    chk("beat_count_lat0", got0, n);
    chk("first_beat_cycle_lat0", first0, 1);
    chk("idle_after_read", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int k, first;
    logic hit;

    rst             = 1'b1;
    mem_read_index  = 1'b0;
    mem_write_index = 1'b0;
    burst           = 1'b0;
    addr_to_mem     = '0;
    data_to_mem     = '0;

    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_0005, 32'h1234_5678, 32'h0000_0005, 32'h1234_5678};
    vecs[2] = '{32'h0000_0408, 32'hCAFE_0008, 32'h0000_0008, 32'hCAFE_0008};
    vecs[3] = '{32'h0000_03FF, 32'h0000_0FFF, 32'hFFFF_FFFF, 32'h0000_0FFF};
    vecs[4] = '{32'h0000_0021, 32'h1111_1111, 32'h0000_0421, 32'h1111_1111};

    tick(); tick(); tick();
    chk("reset_data", data_from_mem, 32'd0);
    chk("reset_rvalid", {31'b0, rvalid}, 32'd0);
    chk("reset_rlast", {31'b0, rlast}, 32'd0);
    chk("reset_wack", {31'b0, wack}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    tick();

    // Write / single-read vectors, including address aliasing
    for (int i = 0; i < 5; i++) begin
      do_write(vecs[i].wa, vecs[i].wd);
      exp_q[0] = vecs[i].exp;
      do_read(vecs[i].ra, 1'b0, 1);
    end

    // Line fill from an unaligned address returns the whole aligned line
    for (int i = 0; i < 8; i++) begin
      do_write(32'h10 + i, 32'hA0 + i);
      exp_q[i] = 32'hA0 + i;
    end
    do_read(32'h13, 1'b1, 8);

    // Write and read together: write wins, held read accepted next edge
    mem_read_index  = 1'b1;
    mem_write_index = 1'b1;
    burst           = 1'b0;
    addr_to_mem     = 32'h20;
    data_to_mem     = 32'h5555_AAAA;
    tick();
    chk("collide_wack", {31'b0, wack}, 32'd1);
    chk("collide_not_busy", {31'b0, busy}, 32'd0);
    mem_write_index = 1'b0;
    tick();
    chk("collide_read_accept", {31'b0, busy}, 32'd1);
    mem_read_index = 1'b0;
    first = -1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (rvalid && first < 0) begin
        first = c;
        chk("collide_read_data", data_from_mem, 32'h5555_AAAA);
      end
    end
    chk("collide_first_beat", first, LAT + 1);

    // Write during WAIT is ignored
    mem_read_index = 1'b1;
    addr_to_mem    = 32'h05;
    tick();
    mem_read_index  = 1'b0;
    mem_write_index = 1'b1;
    data_to_mem     = 32'hBAD0_BAD0;
    tick();
    chk("wait_write_no_wack", {31'b0, wack}, 32'd0);
    chk("wait_busy", {31'b0, busy}, 32'd1);
    mem_write_index = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    chk("wait_done_idle", {31'b0, busy}, 32'd0);
    exp_q[0] = 32'h1234_5678;
    do_read(32'h05, 1'b0, 1);

    // Reset during beat 4 of a line fill
    mem_read_index = 1'b1;
    burst          = 1'b1;
    addr_to_mem    = 32'h10;
    tick();
    mem_read_index = 1'b0;
    burst          = 1'b0;
    k   = 0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      tick();
      if (rvalid) begin
        if (k == 4) hit = 1'b1;
        else k++;
      end
    end
    chk("reset_beat4_reached", {31'b0, hit}, 32'd1);
    chk("beat4_data", data_from_mem, 32'hA4);
    #1 rst = 1'b1;
    #1;
    chk("midreset_rvalid", {31'b0, rvalid}, 32'd0);
    chk("midreset_rlast", {31'b0, rlast}, 32'd0);
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) exp_q[i] = 32'hA0 + i;
    do_read(32'h17, 1'b1, 8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
